// File: rtl/lcd_timing_gen_if.sv
// rtl/lcd_timing_gen_if.sv - pixel request and panel signal bundle for lcd_timing_gen
interface lcd_timing_gen_if;
   logic        pix_req;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic [23:0] pix_rgb;
   logic        frame_start;
   logic        running;
   logic        lcd_hs;
   logic        lcd_vs;
   logic        lcd_de;
   logic [23:0] lcd_rgb;

   modport master (
      output pix_req, pix_x, pix_y, frame_start, running,
      output lcd_hs, lcd_vs, lcd_de, lcd_rgb,
      input  pix_rgb
   );

   modport slave (
      input  pix_req, pix_x, pix_y, frame_start, running,
      input  lcd_hs, lcd_vs, lcd_de, lcd_rgb,
      output pix_rgb
   );
endinterface

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - RGB LCD video timing generator with PLL-lock startup gating
// Stage 0 requests pixels from the counters; stage 1 registers de/hs/vs one clock later.
module lcd_timing_gen #(
   parameter int H_ACTIVE       = 800,
   parameter int H_FP           = 210,
   parameter int H_SYNC         = 20,
   parameter int H_BP           = 26,
   parameter int V_ACTIVE       = 480,
   parameter int V_FP           = 22,
   parameter int V_SYNC         = 10,
   parameter int V_BP           = 13,
   parameter bit SYNC_POL       = 1'b0,
   parameter int STARTUP_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              locked,
   lcd_timing_gen_if.master  bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int SW      = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

   localparam logic [10:0]   H_ACT       = 11'(H_ACTIVE);
   localparam logic [10:0]   H_LAST      = 11'(H_TOTAL - 1);
   localparam logic [10:0]   HS_FIRST    = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0]   HS_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]    V_ACT       = 10'(V_ACTIVE);
   localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0]    VS_FIRST    = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]    VS_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(STARTUP_CYCLES - 1);

   if ((H_TOTAL > 2048) || (V_TOTAL > 1024)) begin : g_width_check
      $error("lcd_timing_gen: timing totals exceed the 11-bit H / 10-bit V counters");
   end

   typedef enum logic [1:0] {WAIT_LOCK, STARTUP, RUN} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [10:0]   hcnt_q, hcnt_d;
   logic [9:0]    vcnt_q, vcnt_d;
   logic          sync1_q, sync2_q;
   logic          de_q, de_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          run;
   logic          pix_req;
   logic          in_hs, in_vs;

   assign run     = (state_q == RUN);
   assign pix_req = run && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
   assign in_hs   = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
   assign in_vs   = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);

   // Losing lock anywhere drops straight back to blanked idle; counters restart from zero.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      hcnt_d   = '0;
      vcnt_d   = '0;
      de_d     = 1'b0;
      hs_d     = ~SYNC_POL;
      vs_d     = ~SYNC_POL;
      case (state_q)
         WAIT_LOCK: begin
            if (sync2_q) begin
               state_d  = STARTUP;
               settle_d = '0;
            end
         end
         STARTUP: begin
            if (!sync2_q)                   state_d  = WAIT_LOCK;
            else if (settle_q == SETTLE_LAST) state_d  = RUN;
            else                            settle_d = settle_q + 1'b1;
         end
         RUN: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
            end else begin
               if (hcnt_q == H_LAST) begin
                  hcnt_d = '0;
                  vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
               end else begin
                  hcnt_d = hcnt_q + 1'b1;
                  vcnt_d = vcnt_q;
               end
               de_d = pix_req;
               hs_d = in_hs ? SYNC_POL : ~SYNC_POL;
               vs_d = in_vs ? SYNC_POL : ~SYNC_POL;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= WAIT_LOCK;
         settle_q <= '0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         de_q     <= 1'b0;
         hs_q     <= ~SYNC_POL;
         vs_q     <= ~SYNC_POL;
      end else begin
         sync1_q  <= locked;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         settle_q <= settle_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
      end
   end

   assign bus.pix_req     = pix_req;
   assign bus.pix_x       = pix_req ? hcnt_q : '0;
   assign bus.pix_y       = pix_req ? vcnt_q : '0;
   assign bus.frame_start = run && (hcnt_q == '0) && (vcnt_q == '0);
   assign bus.running     = run;
   assign bus.lcd_hs      = hs_q;
   assign bus.lcd_vs      = vs_q;
   assign bus.lcd_de      = de_q;
   // Upstream data arrives one clock after the request, i.e. in the lcd_de cycle.
   assign bus.lcd_rgb     = de_q ? bus.pix_rgb : '0;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - scoreboard bench for lcd_timing_gen on a reduced timing
module tb_lcd_timing_gen;
   localparam int HA = 16, HFP = 4, HSW = 3, HBP = 5;
   localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 2;
   localparam int ST = 20;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam int HS0 = HA + HFP, HS1 = HA + HFP + HSW - 1;
   localparam int VS0 = VA + VFP, VS1 = VA + VFP + VSW - 1;

   typedef struct {
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } stage1_t;

   logic clk = 1'b0;
   logic rst_n;
   logic locked;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mh, mv;
   stage1_t sb_q[$];

   lcd_timing_gen_if bus();

   lcd_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(1'b0), .STARTUP_CYCLES(ST)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .locked(locked),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Upstream frame-buffer model: fixed one-clock read latency, garbage when not requested.
   initial begin
      bus.pix_rgb = '0;
      forever begin
         @(posedge clk);
         if (bus.pix_req) bus.pix_rgb = {bus.pix_x[7:0], bus.pix_y[7:0], 8'hA5};
         else             bus.pix_rgb = 24'($urandom);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      locked = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.running, bus.pix_req, bus.frame_start, bus.lcd_de, bus.lcd_hs, bus.lcd_vs} !== 6'b000011) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000011",
                  {bus.running, bus.pix_req, bus.frame_start, bus.lcd_de, bus.lcd_hs, bus.lcd_vs});
      end
      n_checks++;
      if (bus.lcd_rgb !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_rgb: got %h expected 000000", bus.lcd_rgb);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         n_checks++;
         if ({bus.running, bus.pix_req, bus.lcd_de, bus.lcd_hs, bus.lcd_vs} !== 5'b00011) begin
            n_fail++;
            $display("FAIL unlocked_idle cycle %0d: got %b expected 00011", i,
                     {bus.running, bus.pix_req, bus.lcd_de, bus.lcd_hs, bus.lcd_vs});
         end
      end
   endtask

   task automatic test_startup_abort();
      int seen_run;
      seen_run = 0;
      locked = 1'b1;
      for (int i = 0; i < ST / 2; i++) begin
         step();
         if (bus.running) seen_run++;
      end
      locked = 1'b0;
      repeat (5) begin
         step();
         if (bus.running) seen_run++;
      end
      n_checks++;
      if (seen_run != 0 || bus.pix_req !== 1'b0) begin
         n_fail++;
         $display("FAIL startup_abort: running cycles %0d pix_req %b, expected 0 and 0", seen_run, bus.pix_req);
      end
   endtask

   task automatic test_startup();
      int n;
      stage1_t idle;
      n = 0;
      locked = 1'b1;
      while (!bus.running && n < ST + 50) begin
         step();
         n++;
      end
      n_checks++;
      if (n != ST + 3) begin
         n_fail++;
         $display("FAIL startup_latency: running after %0d clks, expected %0d", n, ST + 3);
      end
      n_checks++;
      if ({bus.frame_start, bus.pix_req} !== 2'b11 || bus.pix_x !== 11'd0 || bus.pix_y !== 10'd0) begin
         n_fail++;
         $display("FAIL first_pixel: fs/req %b x %0d y %0d, expected 11 x 0 y 0",
                  {bus.frame_start, bus.pix_req}, bus.pix_x, bus.pix_y);
      end
      mh = 0;
      mv = 0;
      sb_q.delete();
      idle.de = 1'b0; idle.hs = 1'b1; idle.vs = 1'b1; idle.rgb = '0;
      sb_q.push_back(idle);
   endtask

   task automatic test_frames(input int nframes);
      stage1_t     e, nx;
      logic        exp_req;
      logic [10:0] ex;
      logic [9:0]  ey;
      logic [7:0]  xb, yb;
      int          fs_last, de_cnt, vs_cnt, hs_cnt;
      fs_last = -1; de_cnt = 0; vs_cnt = 0; hs_cnt = 0;
      for (int i = 0; i < nframes * FT; i++) begin
         exp_req = (mh < HA) && (mv < VA);
         ex = exp_req ? 11'(mh) : '0;
         ey = exp_req ? 10'(mv) : '0;
         n_checks++;
         if (bus.pix_req !== exp_req || bus.pix_x !== ex || bus.pix_y !== ey) begin
            n_fail++;
            $display("FAIL stage0 at (%0d,%0d): req %b x %0d y %0d, expected req %b x %0d y %0d",
                     mh, mv, bus.pix_req, bus.pix_x, bus.pix_y, exp_req, ex, ey);
         end
         n_checks++;
         if (bus.frame_start !== (mh == 0 && mv == 0)) begin
            n_fail++;
            $display("FAIL frame_start at (%0d,%0d): got %b", mh, mv, bus.frame_start);
         end
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at (%0d,%0d): got 0 entries, expected 1", mh, mv);
         end else begin
            e = sb_q.pop_front();
            if (bus.lcd_de !== e.de || bus.lcd_hs !== e.hs || bus.lcd_vs !== e.vs || bus.lcd_rgb !== e.rgb) begin
               n_fail++;
               $display("FAIL stage1 at (%0d,%0d): de/hs/vs %b rgb %h, expected %b rgb %h", mh, mv,
                        {bus.lcd_de, bus.lcd_hs, bus.lcd_vs}, bus.lcd_rgb, {e.de, e.hs, e.vs}, e.rgb);
            end
         end
         xb = ex[7:0];
         yb = ey[7:0];
         nx.de  = exp_req;
         nx.hs  = !(mh >= HS0 && mh <= HS1);
         nx.vs  = !(mv >= VS0 && mv <= VS1);
         nx.rgb = exp_req ? {xb, yb, 8'hA5} : 24'h0;
         sb_q.push_back(nx);
         if (bus.lcd_de)  de_cnt++;
         if (!bus.lcd_vs) vs_cnt++;
         if (!bus.lcd_hs) hs_cnt++;
         if (bus.frame_start) begin
            if (fs_last >= 0) begin
               n_checks++;
               if (i - fs_last != FT) begin
                  n_fail++;
                  $display("FAIL frame_period: got %0d expected %0d", i - fs_last, FT);
               end
            end
            fs_last = i;
         end
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end
         step();
      end
      n_checks++;
      if (de_cnt != nframes * HA * VA || vs_cnt != nframes * VSW * HT || hs_cnt != nframes * VT * HSW) begin
         n_fail++;
         $display("FAIL frame_totals: de %0d vs %0d hs %0d, expected %0d %0d %0d", de_cnt, vs_cnt, hs_cnt,
                  nframes * HA * VA, nframes * VSW * HT, nframes * VT * HSW);
      end
   endtask

   task automatic test_drop_relock();
      int n;
      n = 0;
      while (!(bus.pix_req && bus.pix_y == 10'd3 && bus.pix_x == 11'd5) && n < FT) begin
         step();
         n++;
      end
      n_checks++;
      if (n >= FT) begin
         n_fail++;
         $display("FAIL drop_position: pixel (5,3) not seen within %0d clks", FT);
      end
      locked = 1'b0;
      step();
      step();
      n_checks++;
      if (bus.running !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_sync_delay: running %b after 2 clks, expected 1", bus.running);
      end
      step();
      n_checks++;
      if ({bus.running, bus.pix_req, bus.frame_start, bus.lcd_de, bus.lcd_hs, bus.lcd_vs} !== 6'b000011
          || bus.lcd_rgb !== 24'h0 || bus.pix_x !== 11'd0 || bus.pix_y !== 10'd0) begin
         n_fail++;
         $display("FAIL drop_outputs: ctrl %b rgb %h x %0d y %0d, expected 000011 rgb 000000 x 0 y 0",
                  {bus.running, bus.pix_req, bus.frame_start, bus.lcd_de, bus.lcd_hs, bus.lcd_vs},
                  bus.lcd_rgb, bus.pix_x, bus.pix_y);
      end
      repeat (20) step();
      n_checks++;
      if ({bus.running, bus.lcd_de, bus.lcd_hs, bus.lcd_vs} !== 4'b0011 || bus.lcd_rgb !== 24'h0) begin
         n_fail++;
         $display("FAIL drop_hold: ctrl %b rgb %h, expected 0011 rgb 000000",
                  {bus.running, bus.lcd_de, bus.lcd_hs, bus.lcd_vs}, bus.lcd_rgb);
      end
      test_startup();
      test_frames(1);
   endtask

   initial begin
      test_reset();
      test_startup_abort();
      test_startup();
      test_frames(2);
      test_drop_relock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
